// File: rtl/wb_arbiter_4to1_pkg.sv
// ============================================================================
//  Module   : wb_arb_pkg
//  Purpose  : Shared constants and types for the writeback-port arbiter.
//             Requester ids, selector width and a one-hot helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_arb_pkg;

  localparam int REQ_N = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] wb_sel_t;

  localparam wb_sel_t REQ_ALU    = 2'd0;
  localparam wb_sel_t REQ_MULDIV = 2'd1;
  localparam wb_sel_t REQ_FPU    = 2'd2;
  localparam wb_sel_t REQ_LOAD   = 2'd3;

  function automatic logic [REQ_N-1:0] sel_onehot(input wb_sel_t sel);
    logic [REQ_N-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_4to1_if.sv
// ============================================================================
//  Module   : wb_arbiter_4to1_if
//  Purpose  : Bundles the four producer result ports and the register-file
//             writeback handshake of the writeback arbiter.
//  Ports    : req_valid/req_data/req_rd/req_ready  producer side
//             mux_select                           writeback data mux select
//             wb_valid/wb_data/wb_rd/wb_ready      register-file side
//  Modports : master - the arbiter (drives req_ready and all wb_* outputs)
//             slave  - the surrounding pipeline / register file
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_arbiter_4to1_if
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);

  logic [REQ_N-1:0]             req_valid;
  logic [REQ_N-1:0][DATA_W-1:0] req_data;
  logic [REQ_N-1:0][RD_W-1:0]   req_rd;
  logic [REQ_N-1:0]             req_ready;
  wb_sel_t                      mux_select;
  logic                         wb_valid;
  logic [DATA_W-1:0]            wb_data;
  logic [RD_W-1:0]              wb_rd;
  logic                         wb_ready;

  modport master (
    input  req_valid, req_data, req_rd, wb_ready,
    output req_ready, mux_select, wb_valid, wb_data, wb_rd
  );

  modport slave (
    output req_valid, req_data, req_rd, wb_ready,
    input  req_ready, mux_select, wb_valid, wb_data, wb_rd
  );

endinterface

`default_nettype wire

// File: rtl/wb_arbiter_4to1_rr_pick4.sv
// ============================================================================
//  Module   : rr_pick4
//  Purpose  : Combinational 4-way round-robin picker. Returns the first set
//             bit of valid searching ptr, ptr+1, ... with 2-bit wrap.
//  Ports    : valid  in  4  candidate requests
//             ptr    in  2  highest-priority position
//             any    out 1  at least one candidate valid
//             winner out 2  id of the chosen candidate (ptr when none)
//             onehot out 4  one-hot of winner, zero when none
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick4
  import wb_arb_pkg::*;
(
  input  logic [REQ_N-1:0] valid,
  input  wb_sel_t          ptr,
  output logic             any,
  output wb_sel_t          winner,
  output logic [REQ_N-1:0] onehot
);

  wb_sel_t w_idx;

  // Walk the search order backwards so the candidate closest to ptr is the
  // last one written and therefore wins.
  always_comb begin
    any    = |valid;
    winner = ptr;
    w_idx  = '0;
    for (int k = REQ_N - 1; k >= 0; k--) begin
      w_idx = ptr + wb_sel_t'(k);
      if (valid[w_idx]) begin
        winner = w_idx;
      end
    end
    onehot = any ? sel_onehot(winner) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter_4to1.sv
// ============================================================================
//  Module   : wb_arbiter_4to1
//  Purpose  : Round-robin arbiter sharing one register-file writeback port
//             between ALU, MUL/DIV, FPU and LOAD result producers. The winning
//             result is captured in a one-entry output stage with a
//             valid/ready handshake toward the register file.
//  Ports    : clk    in  rising-edge clock
//             rst_n  in  asynchronous active-low reset
//             bus    wb_arbiter_4to1_if.master (producer + writeback signals)
//  Config   : WB_ARB_LOAD_PRIO_EN - LOAD (requester 3) wins whenever valid;
//             ALU/MULDIV/FPU round-robin among themselves.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_arbiter_4to1
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
)(
  input  logic                       clk,
  input  logic                       rst_n,
  wb_arbiter_4to1_if.master          bus
);

  wb_sel_t           r_ptr;
  wb_sel_t           r_mux_select;
  logic              r_wb_valid;
  logic [DATA_W-1:0] r_wb_data;
  logic [RD_W-1:0]   r_wb_rd;

  logic [REQ_N-1:0]  w_pick_valid;
  logic              w_pick_any;
  wb_sel_t           w_pick_winner;
  logic [REQ_N-1:0]  w_pick_onehot;
  wb_sel_t           w_winner;
  logic              w_load;

  // The output stage can take a new result when empty or draining this cycle.
  assign w_load = (|bus.req_valid) & (~r_wb_valid | bus.wb_ready);

`ifdef WB_ARB_LOAD_PRIO_EN
  // LOAD is removed from the rotation; ptr only ever holds 0..2 so the
  // masked LOAD slot is simply skipped by the wrap.
  assign w_pick_valid = {1'b0, bus.req_valid[REQ_FPU:REQ_ALU]};
  assign w_winner     = bus.req_valid[REQ_LOAD] ? REQ_LOAD : w_pick_winner;
`else
  assign w_pick_valid = bus.req_valid;
  assign w_winner     = w_pick_winner;
`endif

  rr_pick4 u_pick (
    .valid  (w_pick_valid),
    .ptr    (r_ptr),
    .any    (w_pick_any),
    .winner (w_pick_winner),
    .onehot (w_pick_onehot)
  );

  // The picker's own one-hot only reflects the rotating subset; rebuild it
  // from the final winner so the LOAD override is covered too. rst_n gates
  // it so nothing is accepted while reset is held.
  assign bus.req_ready = (w_load & rst_n) ? sel_onehot(w_winner) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= REQ_ALU;
      r_mux_select <= REQ_ALU;
      r_wb_valid   <= 1'b0;
      r_wb_data    <= '0;
      r_wb_rd      <= '0;
    end else if (w_load) begin
      r_wb_valid   <= 1'b1;
      r_wb_data    <= bus.req_data[w_winner];
      r_wb_rd      <= bus.req_rd[w_winner];
      r_mux_select <= w_winner;
`ifdef WB_ARB_LOAD_PRIO_EN
      if (w_winner != REQ_LOAD) begin
        r_ptr <= (w_winner == REQ_FPU) ? REQ_ALU : w_winner + wb_sel_t'(1);
      end
`else
      r_ptr <= w_winner + wb_sel_t'(1);
`endif
    end else if (r_wb_valid & bus.wb_ready) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign bus.mux_select = r_mux_select;
  assign bus.wb_valid   = r_wb_valid;
  assign bus.wb_data    = r_wb_data;
  assign bus.wb_rd      = r_wb_rd;

  // Picker "any" and one-hot are redundant with the reconstruction above.
  logic w_unused;
  assign w_unused = w_pick_any ^ (|w_pick_onehot);

endmodule

`default_nettype wire
